// File: rtl/serial_shifter_pkg.sv
// serial_shifter_pkg: shift type codes and FSM state encoding shared with the ALU.
package serial_shifter_pkg;
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_BAD = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_shifter_shift_step.sv
// shift_step: one iteration of the serial shifter, moving acc by 1 or 4 bits.
module shift_step
    import serial_shifter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] acc,
    input  logic [1:0]      shift_type,
    input  logic            sign,
    input  logic            four,
    output logic [XLEN-1:0] nxt
);
    logic fill;
    // Right shifts share one path; only SRA feeds the latched sign into the top.
    assign fill = (shift_type == SHIFT_SRA) && sign;
    assign nxt = shift_type == SHIFT_SLL ? (four ? {acc[XLEN-5:0], 4'b0} : {acc[XLEN-2:0], 1'b0}) :
                 shift_type == SHIFT_BAD ? acc :
                 (four ? {{4{fill}}, acc[XLEN-1:4]} : {fill, acc[XLEN-1:1]});
endmodule

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle SLL/SRL/SRA unit with start/busy/done handshake.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FAST_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     flush,
    input  logic [XLEN-1:0]          a,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    input  logic [1:0]               shift_type,
    output logic                     busy,
    output logic                     done,
    output logic [XLEN-1:0]          r
);
    localparam int CW = $clog2(XLEN);
    state_t          state;
    logic [XLEN-1:0] acc, nxt;
    logic [CW-1:0]   count, step, count_nxt;
    logic [1:0]      type_q;
    logic            sign_q, four;
    assign four      = (FAST_STEP != 0) && (count >= CW'(4));
    assign step      = four ? CW'(4) : CW'(1);
    assign count_nxt = count - step;
    shift_step #(.XLEN(XLEN)) u_step (
        .acc        (acc),
        .shift_type (type_q),
        .sign       (sign_q),
        .four       (four),
        .nxt        (nxt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            r      <= '0;
            acc    <= '0;
            count  <= '0;
            type_q <= '0;
            sign_q <= 1'b0;
        end else if (flush && state != ST_IDLE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start && !flush && state != ST_SHIFT) begin
            acc    <= a;
            count  <= shamt;
            type_q <= shift_type;
            sign_q <= a[XLEN-1];
            // Invalid type and zero shift both finish without entering SHIFT.
            if (shift_type == SHIFT_BAD || shamt == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                r     <= shift_type == SHIFT_BAD ? '0 : a;
            end else begin
                state <= ST_SHIFT;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else if (state == ST_SHIFT) begin
            acc   <= nxt;
            count <= count_nxt;
            if (count_nxt == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                r     <= nxt;
            end
        end else if (state == ST_DONE) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: directed and random checks of serial_shifter against a plain-arithmetic model.
module tb_serial_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  shift_type = '0;
    logic        busy, done;
    logic [31:0] r;
    int checks = 0;
    int errors = 0;

    serial_shifter #(.XLEN(32), .FAST_STEP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush      (flush),
        .a          (a),
        .shamt      (shamt),
        .shift_type (shift_type),
        .busy       (busy),
        .done       (done),
        .r          (r)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_r(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] tv);
        logic signed [31:0] s;
        s = av;
        case (tv)
            2'b00:   return av << sv;
            2'b01:   return av >> sv;
            2'b10:   return s >>> sv;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sv, input logic [1:0] tv);
        if (tv == 2'b11 || sv == 0) return 1;
        return int'(sv) / 4 + int'(sv) % 4 + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request now, let the next edge accept it, then scramble the inputs.
    task automatic issue(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] tv);
        start = 1'b1; a = av; shamt = sv; shift_type = tv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; shamt = 5'($urandom); shift_type = 2'($urandom);
    endtask

    task automatic wait_done(input logic [31:0] er, input int el, input bit poke);
        int lat = 1;
        int bc = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) bc++;
            if (poke && lat == 3) begin
                start = 1'b1; a = $urandom; shamt = 5'd0; shift_type = 2'b00;
            end else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(el));
        chk("result", r, er);
        chk("busy_cycles", 32'(bc), 32'(el - 1));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] tv);
        @(negedge clk);
        issue(av, sv, tv);
        wait_done(model_r(av, sv, tv), model_lat(sv, tv), 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] prev, av;
        logic [4:0]  sv;
        logic [1:0]  tv;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_r", r, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(32'h0000_0001, 5'd31, 2'b00);
        do_op(32'hF000_0000, 5'd4, 2'b10);
        do_op(32'hF000_0000, 5'd4, 2'b01);
        do_op(32'hDEAD_BEEF, 5'd0, 2'b01);
        do_op(32'h1234_5678, 5'd7, 2'b11);
        for (int i = 0; i < 20; i++) begin
            tv = 2'($urandom_range(0, 2));
            do_op($urandom, 5'($urandom), tv);
        end

        // Flush mid-shift: no done, r keeps the previous result.
        prev = r;
        @(negedge clk);
        issue(32'hABCD_1234, 5'd20, 2'b01);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_r", r, prev);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_r_held", r, prev);
        issue(32'h8000_0F00, 5'd9, 2'b10);
        wait_done(model_r(32'h8000_0F00, 5'd9, 2'b10), model_lat(5'd9, 2'b10), 1'b0);

        // Back-to-back: request issued while done is high.
        issue(32'h0000_00FF, 5'd6, 2'b00);
        wait_done(32'h0000_3FC0, model_lat(5'd6, 2'b00), 1'b0);
        issue(32'h5555_0000, 5'd0, 2'b00);
        wait_done(32'h5555_0000, 1, 1'b0);
        issue(32'h0000_0077, 5'd0, 2'b01);
        wait_done(32'h0000_0077, 1, 1'b0);

        // A start mid-SHIFT must be ignored.
        @(negedge clk);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        av = $urandom; sv = 5'd23; tv = 2'b10;
        issue(av, sv, tv);
        wait_done(model_r(av, sv, tv), model_lat(sv, tv), 1'b1);

        // Asynchronous reset mid-shift.
        @(negedge clk);
        issue(32'h0000_0001, 5'd31, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_r", r, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("arst_quiet", 32'(seen), 32'd0);
        do_op(32'hC000_0003, 5'd2, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
